cflow_mr: RTL and testbench

- Parametrised successor to the single-region CFA monitor.
- Watches the MSP430 PC across NUM_ER independently enabled executable regions (ERs), detects non-sequential transfers inside any enabled ER, compresses repeated loops into counter words, and streams the log as 16-bit words to the CFLog memory.
- Owns a flush handshake with the TCB, ER write protection, and the boot/ER-done signals feeding the ACFA NMI.

---
 rtl/cflow_pkg.sv | 22 ++
 rtl/cflow_er_match.sv | 12 +
 rtl/cflow_mr.sv | 227 ++++++++++++++++++++++
 tb/tb_cflow_mr.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cflow_pkg.sv
// Shared types and constants for the multi-region control-flow monitor.
package cflow_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WR_CTR = 3'd1,
      WR_SRC = 3'd2,
      WR_DST = 3'd3,
      FLUSH  = 3'd4
   } state_t;

   localparam logic        CTR_MARK     = 1'b1;
   localparam logic [15:0] DEF_TCB_MAX  = 16'hdffe;
   localparam logic [15:0] DEF_PMEM_MIN = 16'he03e;
   localparam logic [15:0] DEF_LOG_SIZE = 16'h0080;

   // Log words a pop will produce: optional counter word plus optional src/dst pair.
   function automatic logic [1:0] words_needed(input logic ctr_nonzero, input logic emit_pair);
      words_needed = {emit_pair, 1'b0} + {1'b0, ctr_nonzero};
   endfunction

endpackage

// File: rtl/cflow_er_match.sv
// Inclusive address range comparator for one executable region.
module cflow_er_match (
   input  logic [15:0] addr,
   input  logic [15:0] min_addr,
   input  logic [15:0] max_addr,
   input  logic        en,
   output logic        hit_c
);

   assign hit_c = en & (addr >= min_addr) & (addr <= max_addr);

endmodule

// File: rtl/cflow_mr.sv
// Multi-region control-flow monitor: logs branches inside enabled regions with loop
// compression, manages log flushes, region protection and boot/region-done pulses.
module cflow_mr
   import cflow_pkg::*;
#(
   parameter int unsigned NUM_ER   = 2,
   parameter logic [15:0] LOG_SIZE = DEF_LOG_SIZE,
   parameter int unsigned CTR_W    = 15,
   parameter logic [15:0] TCB_MAX  = DEF_TCB_MAX,
   parameter logic [15:0] PMEM_MIN = DEF_PMEM_MIN
) (
   input  logic                   clk,
   input  logic                   puc,
   input  logic [15:0]            pc,
   input  logic [15:0]            pc_nxt,
   input  logic                   pc_upd,
   input  logic [1:0]             inst_len,
   input  logic [16*NUM_ER-1:0]   er_min,
   input  logic [16*NUM_ER-1:0]   er_max,
   input  logic [NUM_ER-1:0]      er_en,
   input  logic                   data_wr,
   input  logic [15:0]            data_addr,
   input  logic                   dma_en,
   input  logic [15:0]            dma_addr,
   input  logic                   flush_ack,
   output logic                   log_wen,
   output logic [15:0]            log_ptr,
   output logic [15:0]            log_data,
   output logic                   flush,
   output logic [NUM_ER-1:0]      er_done,
   output logic                   boot,
   output logic                   violation,
   output logic                   log_overrun
);

   localparam logic [CTR_W-1:0] CTR_MAX = '1;

   state_t            state, state_nxt;
   logic [NUM_ER-1:0] pc_hit, nxt_hit, wr_hit, dma_hit;
   logic [15:0]       seq_pc;
   logic              in_er, entry_bad, branch, viol_set;
   logic [15:0]       fifo_src [2];
   logic [15:0]       fifo_dst [2];
   logic              rd_idx, wr_idx;
   logic [1:0]        count;
   logic              push, pop, ctr_inc;
   logic [15:0]       head_src, head_dst, last_src, last_dst;
   logic              last_valid, seq_pair, pair_hit, ctr_nz, fits;
   logic [CTR_W-1:0]  ctr;
   logic [1:0]        need;
   logic              log_wen_nxt, flush_nxt;
   logic [15:0]       log_data_nxt;
   logic              tcb_boot_done;
   logic [15:0]       pc_prev;
   logic [NUM_ER-1:0] er_done_nxt;

   for (genvar i = 0; i < NUM_ER; i++) begin : g_er
      cflow_er_match u_pc  (.addr(pc),        .min_addr(er_min[16*i +: 16]), .max_addr(er_max[16*i +: 16]),
                            .en(er_en[i]),    .hit_c(pc_hit[i]));
      cflow_er_match u_nxt (.addr(pc_nxt),    .min_addr(er_min[16*i +: 16]), .max_addr(er_max[16*i +: 16]),
                            .en(er_en[i]),    .hit_c(nxt_hit[i]));
      cflow_er_match u_wr  (.addr(data_addr), .min_addr(er_min[16*i +: 16]), .max_addr(er_max[16*i +: 16]),
                            .en(er_en[i]),    .hit_c(wr_hit[i]));
      cflow_er_match u_dma (.addr(dma_addr),  .min_addr(er_min[16*i +: 16]), .max_addr(er_max[16*i +: 16]),
                            .en(er_en[i]),    .hit_c(dma_hit[i]));
   end

   // Entry must land on the start of the lowest-indexed region hit; descending loop lets it win.
   always_comb begin
      entry_bad = 1'b0;
      for (int i = int'(NUM_ER) - 1; i >= 0; i--)
         if (nxt_hit[i]) entry_bad = (pc_nxt != er_min[16*i +: 16]);
   end

   assign seq_pc   = pc + {13'd0, inst_len, 1'b0};
   assign in_er    = |pc_hit;
   assign branch   = pc_upd & in_er & ~violation & (pc_nxt != seq_pc);
   assign push     = branch & (count != 2'd2);
   assign viol_set = (data_wr & |wr_hit) | (dma_en & |dma_hit) | (pc_upd & ~in_er & entry_bad);
   assign head_src = fifo_src[rd_idx];
   assign head_dst = fifo_dst[rd_idx];

   // Two-entry pending pair FIFO
   always_ff @(posedge clk or posedge puc) begin
      if (puc) begin
         fifo_src[0] <= '0;
         fifo_src[1] <= '0;
         fifo_dst[0] <= '0;
         fifo_dst[1] <= '0;
         rd_idx      <= 1'b0;
         wr_idx      <= 1'b0;
         count       <= 2'd0;
      end else begin
         if (push) begin
            fifo_src[wr_idx] <= pc;
            fifo_dst[wr_idx] <= pc_nxt;
            wr_idx           <= ~wr_idx;
         end
         if (pop) rd_idx <= ~rd_idx;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge puc) begin
      if (puc) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      pop          = 1'b0;
      ctr_inc      = 1'b0;
      log_wen_nxt  = 1'b0;
      log_data_nxt = '0;
      flush_nxt    = 1'b0;
      pair_hit     = last_valid & (head_src == last_src) & (head_dst == last_dst);
      ctr_nz       = (ctr != '0);
      need         = pair_hit ? words_needed(1'b1, 1'b0) : words_needed(ctr_nz, 1'b1);
      fits         = (17'(log_ptr) + 17'(need)) <= 17'(LOG_SIZE);
      case (state)
         IDLE: begin
            if (count != 2'd0) begin
               if (pair_hit && (ctr != CTR_MAX)) begin
                  pop     = 1'b1;
                  ctr_inc = 1'b1;
               end else if (!fits) begin
                  state_nxt = FLUSH;
                  flush_nxt = 1'b1;
               end else begin
                  pop         = 1'b1;
                  log_wen_nxt = 1'b1;
                  if (pair_hit || ctr_nz) begin
                     state_nxt    = WR_CTR;
                     log_data_nxt = 16'({ctr, CTR_MARK});
                  end else begin
                     state_nxt    = WR_SRC;
                     log_data_nxt = head_src;
                  end
               end
            end
         end
         WR_CTR: begin
            if (seq_pair) begin
               state_nxt    = WR_SRC;
               log_wen_nxt  = 1'b1;
               log_data_nxt = last_src;
            end else begin
               state_nxt = IDLE;
            end
         end
         WR_SRC: begin
            state_nxt    = WR_DST;
            log_wen_nxt  = 1'b1;
            log_data_nxt = last_dst;
         end
         WR_DST: state_nxt = IDLE;
         FLUSH: begin
            if (flush_ack) state_nxt = IDLE;
            else           flush_nxt = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Loop compression state and log write pointer
   always_ff @(posedge clk or posedge puc) begin
      if (puc) begin
         ctr        <= '0;
         last_src   <= '0;
         last_dst   <= '0;
         last_valid <= 1'b0;
         seq_pair   <= 1'b0;
         log_ptr    <= '0;
         log_wen    <= 1'b0;
         log_data   <= '0;
         flush      <= 1'b0;
      end else begin
         if (ctr_inc)               ctr <= ctr + CTR_W'(1);
         else if (state == WR_CTR)  ctr <= seq_pair ? '0 : CTR_W'(1);
         if (pop && !ctr_inc) begin
            seq_pair <= ~pair_hit;
            if (!pair_hit) begin
               last_src   <= head_src;
               last_dst   <= head_dst;
               last_valid <= 1'b1;
            end
         end
         if ((state == FLUSH) && flush_ack)                               log_ptr <= '0;
         else if ((state == WR_CTR) || (state == WR_SRC) || (state == WR_DST)) log_ptr <= log_ptr + 16'd1;
         log_wen  <= log_wen_nxt;
         log_data <= log_data_nxt;
         flush    <= flush_nxt;
      end
   end

   always_comb begin
      er_done_nxt = '0;
      for (int i = 0; i < int'(NUM_ER); i++)
         er_done_nxt[i] = tcb_boot_done & er_en[i] & (pc == er_max[16*i +: 16]) &
                          (pc_prev != er_max[16*i +: 16]);
   end

   // Protection, boot tracking and arrival pulses
   always_ff @(posedge clk or posedge puc) begin
      if (puc) begin
         violation     <= 1'b0;
         log_overrun   <= 1'b0;
         tcb_boot_done <= 1'b0;
         pc_prev       <= '0;
         er_done       <= '0;
         boot          <= 1'b0;
      end else begin
         if (viol_set)                    violation   <= 1'b1;
         if (branch && (count == 2'd2))   log_overrun <= 1'b1;
         if (pc == TCB_MAX)               tcb_boot_done <= 1'b1;
         else if (violation)              tcb_boot_done <= 1'b0;
         pc_prev <= pc;
         er_done <= er_done_nxt;
         boot    <= (pc == PMEM_MIN) & (pc_prev != PMEM_MIN);
      end
   end

endmodule

// File: tb/tb_cflow_mr.sv
// Directed self-checking bench for cflow_mr with a 4-word log to exercise flushes.
module tb_cflow_mr;

   localparam logic [15:0] IDLE_PC = 16'h4000;

   logic        clk, puc;
   logic [15:0] pc, pc_nxt;
   logic        pc_upd;
   logic [1:0]  inst_len;
   logic [31:0] er_min, er_max;
   logic [1:0]  er_en;
   logic        data_wr, dma_en, flush_ack;
   logic [15:0] data_addr, dma_addr;
   logic        log_wen, flush, boot, violation, log_overrun;
   logic [15:0] log_ptr, log_data;
   logic [1:0]  er_done;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [31:0] wlog [$];

   cflow_mr #(.NUM_ER(2), .LOG_SIZE(16'h0004), .CTR_W(15)) dut (
      .clk(clk), .puc(puc), .pc(pc), .pc_nxt(pc_nxt), .pc_upd(pc_upd), .inst_len(inst_len),
      .er_min(er_min), .er_max(er_max), .er_en(er_en), .data_wr(data_wr), .data_addr(data_addr),
      .dma_en(dma_en), .dma_addr(dma_addr), .flush_ack(flush_ack), .log_wen(log_wen),
      .log_ptr(log_ptr), .log_data(log_data), .flush(flush), .er_done(er_done), .boot(boot),
      .violation(violation), .log_overrun(log_overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (log_wen === 1'b1) wlog.push_back({log_ptr, log_data});

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] log_at(input int idx);
      return (idx < wlog.size()) ? wlog[idx] : 32'hffff_ffff;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic branch(input logic [15:0] s, input logic [15:0] d);
      pc = s; pc_nxt = d; pc_upd = 1'b1; inst_len = 2'd1;
      idle(1);
      pc_upd = 1'b0; pc = IDLE_PC; pc_nxt = IDLE_PC;
   endtask

   task automatic ack();
      flush_ack = 1'b1;
      idle(1);
      flush_ack = 1'b0;
   endtask

   initial begin
      clk = 1'b0; puc = 1'b1;
      pc = IDLE_PC; pc_nxt = IDLE_PC; pc_upd = 1'b0; inst_len = 2'd1;
      er_min = {16'he300, 16'he100}; er_max = {16'he3fe, 16'he1fe}; er_en = 2'b11;
      data_wr = 1'b0; data_addr = '0; dma_en = 1'b0; dma_addr = '0; flush_ack = 1'b0;
      idle(2);
      puc = 1'b0;
      @(negedge clk);
      check("rst_wen", 32'(log_wen), 32'd0);
      check("rst_ptr", 32'(log_ptr), 32'd0);
      check("rst_data", 32'(log_data), 32'd0);
      check("rst_flush", 32'(flush), 32'd0);
      check("rst_er_done", 32'(er_done), 32'd0);
      check("rst_boot", 32'(boot), 32'd0);
      check("rst_viol", 32'(violation), 32'd0);
      check("rst_overrun", 32'(log_overrun), 32'd0);
      idle(1);

      // First branch: cycle-exact write timing
      branch(16'he120, 16'he180);
      @(negedge clk); check("pop_cycle_wen", 32'(log_wen), 32'd0);
      @(negedge clk); check("w0", {15'd0, log_wen, log_ptr, log_data}, {15'd0, 1'b1, 16'd0, 16'he120});
      @(negedge clk); check("w1", {15'd0, log_wen, log_ptr, log_data}, {15'd0, 1'b1, 16'd1, 16'he180});
      @(negedge clk); check("w_end", {15'd0, log_wen, log_ptr}, {15'd0, 1'b0, 16'd2});
      idle(1);

      // Sequential flow inside a region and a jump outside all regions are not logged
      pc = 16'he150; pc_nxt = 16'he154; inst_len = 2'd2; pc_upd = 1'b1; idle(1);
      pc = IDLE_PC; pc_nxt = 16'h5000; inst_len = 2'd1; idle(1);
      pc_upd = 1'b0; pc_nxt = IDLE_PC; idle(4);
      check("seq_no_log", 32'(wlog.size()), 32'd2);
      check("seq_ptr", 32'(log_ptr), 32'd2);
      check("seq_viol", 32'(violation), 32'd0);

      // Loop compression: 4 repeats then a new pair needing 3 words forces a flush
      repeat (4) begin
         branch(16'he120, 16'he180);
         idle(2);
      end
      branch(16'he190, 16'he100);
      idle(4);
      check("loop_flush", 32'(flush), 32'd1);
      check("loop_no_write", 32'(wlog.size()), 32'd2);
      ack();
      check("ack_flush_low", 32'(flush), 32'd0);
      check("ack_ptr_zero", 32'(log_ptr), 32'd0);
      idle(6);
      check("ctr_word", log_at(2), {16'd0, 16'h0009});
      check("loop_src", log_at(3), {16'd1, 16'he190});
      check("loop_dst", log_at(4), {16'd2, 16'he100});
      check("loop_ptr", 32'(log_ptr), 32'd3);

      // log_ptr=3 with a 2-word pair pending: flush, hold 10 cycles, then retry at 0
      branch(16'he1a0, 16'he1c0);
      idle(10);
      check("full_flush", 32'(flush), 32'd1);
      check("full_no_write", 32'(wlog.size()), 32'd5);
      ack();
      idle(5);
      check("retry_src", log_at(5), {16'd0, 16'he1a0});
      check("retry_dst", log_at(6), {16'd1, 16'he1c0});
      check("retry_ptr", 32'(log_ptr), 32'd2);
      check("no_overrun_yet", 32'(log_overrun), 32'd0);

      // Stray ack outside FLUSH is ignored
      ack();
      idle(2);
      check("stray_ack_ptr", 32'(log_ptr), 32'd2);
      check("stray_ack_flush", 32'(flush), 32'd0);

      // Fill the log exactly, then overflow the pending FIFO during a flush
      branch(16'he110, 16'he130);
      idle(5);
      check("fill_src", log_at(7), {16'd2, 16'he110});
      check("fill_dst", log_at(8), {16'd3, 16'he130});
      check("fill_ptr", 32'(log_ptr), 32'd4);
      branch(16'he140, 16'he160);
      idle(3);
      pc_upd = 1'b1; inst_len = 2'd1;
      pc = 16'he170; pc_nxt = 16'he1b0; idle(1);
      pc = 16'he1d0; pc_nxt = 16'he1e0; idle(1);
      pc = 16'he1e2; pc_nxt = 16'he100; idle(1);
      pc_upd = 1'b0; pc = IDLE_PC; pc_nxt = IDLE_PC;
      idle(2);
      check("ovr_flag", 32'(log_overrun), 32'd1);
      check("ovr_flush", 32'(flush), 32'd1);
      check("ovr_no_write", 32'(wlog.size()), 32'd9);
      ack();
      idle(8);
      check("ovr_b_src", log_at(9),  {16'd0, 16'he140});
      check("ovr_b_dst", log_at(10), {16'd1, 16'he160});
      check("ovr_c_src", log_at(11), {16'd2, 16'he170});
      check("ovr_c_dst", log_at(12), {16'd3, 16'he1b0});
      check("ovr_dropped", 32'(wlog.size()), 32'd13);

      // TCB boot then arrival at the end of region 1; boot pulse at application entry
      pc = 16'hdffe; idle(1);
      pc = 16'he3fe; idle(1);
      check("er_done_pulse", 32'(er_done), 32'd2);
      idle(1);
      check("er_done_once", 32'(er_done), 32'd0);
      pc = 16'he03e; idle(1);
      check("boot_pulse", 32'(boot), 32'd1);
      idle(1);
      check("boot_once", 32'(boot), 32'd0);
      pc = IDLE_PC; idle(1);

      // CPU write into a region: sticky violation blocks logging and clears boot-done
      data_wr = 1'b1; data_addr = 16'he150; idle(1);
      data_wr = 1'b0;
      check("wr_viol", 32'(violation), 32'd1);
      branch(16'he120, 16'he1f0);
      idle(5);
      check("viol_no_push", 32'(flush), 32'd0);
      check("viol_no_write", 32'(wlog.size()), 32'd13);
      check("viol_sticky", 32'(violation), 32'd1);
      pc = 16'he3fe; idle(1);
      check("viol_no_er_done", 32'(er_done), 32'd0);
      pc = IDLE_PC;

      // puc clears everything
      puc = 1'b1; idle(1); puc = 1'b0;
      check("puc_viol", 32'(violation), 32'd0);
      check("puc_ptr", 32'(log_ptr), 32'd0);
      check("puc_overrun", 32'(log_overrun), 32'd0);

      // Region entry checks
      pc = IDLE_PC; pc_nxt = 16'he100; pc_upd = 1'b1; idle(1);
      pc_upd = 1'b0;
      check("legal_entry", 32'(violation), 32'd0);
      pc_nxt = 16'he302; pc_upd = 1'b1; idle(1);
      pc_upd = 1'b0; pc_nxt = IDLE_PC;
      check("mid_entry", 32'(violation), 32'd1);

      // DMA accesses
      puc = 1'b1; idle(1); puc = 1'b0;
      dma_en = 1'b1; dma_addr = 16'h2000; idle(1);
      check("dma_outside", 32'(violation), 32'd0);
      dma_addr = 16'he310; idle(1);
      dma_en = 1'b0;
      check("dma_inside", 32'(violation), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
